// File: rtl/fp_sign_pkg.sv
// Shared definitions for the single-precision sign-injection / classify unit:
// op encodings, FCLASS bit positions, field widths and the sign-injection helper.
package fp_sign_pkg;

    localparam int FP_W     = 32;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int SIGN_BIT = FP_W - 1;
    localparam int CLASS_W  = 10;

    localparam logic [1:0] OP_FSGNJ  = 2'b00;
    localparam logic [1:0] OP_FSGNJN = 2'b01;
    localparam logic [1:0] OP_FSGNJX = 2'b10;
    localparam logic [1:0] OP_FCLASS = 2'b11;

    localparam int CLS_NEG_INF  = 0;
    localparam int CLS_NEG_NORM = 1;
    localparam int CLS_NEG_SUB  = 2;
    localparam int CLS_NEG_ZERO = 3;
    localparam int CLS_POS_ZERO = 4;
    localparam int CLS_POS_SUB  = 5;
    localparam int CLS_POS_NORM = 6;
    localparam int CLS_POS_INF  = 7;
    localparam int CLS_SNAN     = 8;
    localparam int CLS_QNAN     = 9;

    typedef struct packed {
        logic [FP_W-1:0] rs1;
        logic [FP_W-1:0] rs2;
        logic [1:0]      op;
    } fp_req_t;

    // Only the sign bit is rewritten, so NaN payloads travel through untouched.
    function automatic logic [FP_W-1:0] sign_inject(input logic [1:0]      op,
                                                    input logic [FP_W-1:0] a,
                                                    input logic [FP_W-1:0] b);
        logic sgn;
        case (op)
            OP_FSGNJ:  sgn = b[SIGN_BIT];
            OP_FSGNJN: sgn = ~b[SIGN_BIT];
            OP_FSGNJX: sgn = a[SIGN_BIT] ^ b[SIGN_BIT];
            default:   sgn = a[SIGN_BIT];
        endcase
        return {sgn, a[FP_W-2:0]};
    endfunction

endpackage

// File: rtl/fp_class.sv
// Combinational single-precision classifier producing a 10-bit one-hot class
// vector in the FCLASS.S bit order.
module fp_class
    import fp_sign_pkg::*;
(
    input  logic [FP_W-1:0]    operand,
    output logic [CLASS_W-1:0] fclass
);

    logic             sign_s;
    logic [EXP_W-1:0] exp_s;
    logic [MAN_W-1:0] man_s;

    assign sign_s = operand[SIGN_BIT];
    assign exp_s  = operand[FP_W-2:MAN_W];
    assign man_s  = operand[MAN_W-1:0];

    // Decode exponent/mantissa into exactly one class bit; mantissa MSB separates quiet from signalling NaN.
    always_comb begin
        fclass = {CLASS_W{1'b0}};
        if (exp_s == {EXP_W{1'b1}}) begin
            if (man_s == {MAN_W{1'b0}}) begin
                if (sign_s) begin
                    fclass[CLS_NEG_INF] = 1'b1;
                end else begin
                    fclass[CLS_POS_INF] = 1'b1;
                end
            end else if (man_s[MAN_W-1]) begin
                fclass[CLS_QNAN] = 1'b1;
            end else begin
                fclass[CLS_SNAN] = 1'b1;
            end
        end else if (exp_s == {EXP_W{1'b0}}) begin
            if (man_s == {MAN_W{1'b0}}) begin
                if (sign_s) begin
                    fclass[CLS_NEG_ZERO] = 1'b1;
                end else begin
                    fclass[CLS_POS_ZERO] = 1'b1;
                end
            end else if (sign_s) begin
                fclass[CLS_NEG_SUB] = 1'b1;
            end else begin
                fclass[CLS_POS_SUB] = 1'b1;
            end
        end else if (sign_s) begin
            fclass[CLS_NEG_NORM] = 1'b1;
        end else begin
            fclass[CLS_POS_NORM] = 1'b1;
        end
    end

endmodule

// File: rtl/fp_sign_exec.sv
// Two-stage valid/ready execution unit for FSGNJ.S / FSGNJN.S / FSGNJX.S and,
// when FP_SIGN_EXEC_FCLASS_EN is defined, FCLASS.S; keeps a completion counter.
module fp_sign_exec
    import fp_sign_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_rd,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic             busy,
    output logic [15:0]      op_count
);

    logic             s1_v_r;
    fp_req_t          s1_req_r;
    logic [TAG_W-1:0] s1_tag_r;

    logic             s2_v_r;
    logic [FP_W-1:0]  s2_rd_r;
    logic [TAG_W-1:0] s2_tag_r;
    logic             s2_ill_r;

    logic [15:0]      op_count_r;

    logic             s2_free_s;
    logic             in_ready_s;
    logic             out_hs_s;
    logic [FP_W-1:0]  rd_s;
    logic             ill_s;

    assign s2_free_s  = !s2_v_r || out_ready;
    assign in_ready_s = !s1_v_r || s2_free_s;
    assign out_hs_s   = s2_v_r && out_ready;

`ifdef FP_SIGN_EXEC_FCLASS_EN
    logic [CLASS_W-1:0] class_s;

    fp_class u_fp_class (
        .operand (s1_req_r.rs1),
        .fclass  (class_s)
    );
`endif

    // Result selection for the operation sitting in S1.
    always_comb begin
        rd_s  = {FP_W{1'b0}};
        ill_s = 1'b0;
        case (s1_req_r.op)
            OP_FCLASS: begin
`ifdef FP_SIGN_EXEC_FCLASS_EN
                rd_s  = {{(FP_W-CLASS_W){1'b0}}, class_s};
                ill_s = 1'b0;
`else
                rd_s  = s1_req_r.rs1;
                ill_s = 1'b1;
`endif
            end
            default: begin
                rd_s  = sign_inject(s1_req_r.op, s1_req_r.rs1, s1_req_r.rs2);
                ill_s = 1'b0;
            end
        endcase
    end

    // S1: capture a new request whenever the stage is empty or emptying this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_r   <= 1'b0;
            s1_req_r <= '0;
            s1_tag_r <= {TAG_W{1'b0}};
        end else if (in_ready_s) begin
            s1_v_r <= in_valid;
            if (in_valid) begin
                s1_req_r.rs1 <= in_rs1;
                s1_req_r.rs2 <= in_rs2;
                s1_req_r.op  <= in_op;
                s1_tag_r     <= in_tag;
            end
        end
    end

    // S2: hold the result stable under backpressure, reload when it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_r   <= 1'b0;
            s2_rd_r  <= {FP_W{1'b0}};
            s2_tag_r <= {TAG_W{1'b0}};
            s2_ill_r <= 1'b0;
        end else if (s2_free_s) begin
            s2_v_r <= s1_v_r;
            if (s1_v_r) begin
                s2_rd_r  <= rd_s;
                s2_tag_r <= s1_tag_r;
                s2_ill_r <= ill_s;
            end
        end
    end

    // Completion counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_r <= 16'd0;
        end else if (out_hs_s) begin
            op_count_r <= op_count_r + 16'd1;
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = s2_v_r;
    assign out_rd      = s2_rd_r;
    assign out_tag     = s2_tag_r;
    assign out_illegal = s2_ill_r;
    assign busy        = s1_v_r || s2_v_r;
    assign op_count    = op_count_r;

endmodule

// File: tb/tb_fp_sign_exec.sv
// Scoreboard testbench for fp_sign_exec; expectations come from a behavioural
// model of the instruction set, honouring FP_SIGN_EXEC_FCLASS_EN like the design.
module tb_fp_sign_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [1:0]  in_op;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rd;
    logic [3:0]  out_tag;
    logic        out_illegal;
    logic        busy;
    logic [15:0] op_count;

    typedef struct packed {
        logic [31:0] rd;
        logic [3:0]  tag;
        logic        ill;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;
    bit          lat_chk = 1'b0;
    bit          rand_bp = 1'b0;
    bit          hold_v = 1'b0;
    logic [31:0] hold_rd;
    logic [3:0]  hold_tag;
    logic        hold_ill;
    logic [15:0] exp_cnt = 16'd0;

    fp_sign_exec #(.TAG_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_op       (in_op),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rd      (out_rd),
        .out_tag     (out_tag),
        .out_illegal (out_illegal),
        .busy        (busy),
        .op_count    (op_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    function automatic logic [9:0] ref_class(input logic [31:0] a);
        logic is_inf, is_nan, is_zero, is_sub;
        int   idx;
        is_inf  = (a[30:0] == 31'h7F800000);
        is_nan  = (a[30:23] == 8'hFF) && !is_inf;
        is_zero = (a[30:0] == 31'h0);
        is_sub  = (a[30:23] == 8'h00) && !is_zero;
        if (is_nan)       idx = a[22] ? 9 : 8;
        else if (is_inf)  idx = a[31] ? 0 : 7;
        else if (is_zero) idx = a[31] ? 3 : 4;
        else if (is_sub)  idx = a[31] ? 2 : 5;
        else              idx = a[31] ? 1 : 6;
        return 10'd1 << idx;
    endfunction

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] tag);
        exp_t e;
        e.tag = tag;
        e.ill = 1'b0;
        e.cyc = 0;
        case (op)
            2'd0: e.rd = {b[31], a[30:0]};
            2'd1: e.rd = {~b[31], a[30:0]};
            2'd2: e.rd = {a[31] ^ b[31], a[30:0]};
            default: begin
`ifdef FP_SIGN_EXEC_FCLASS_EN
                e.rd = {22'd0, ref_class(a)};
`else
                e.rd = a;
                e.ill = 1'b1;
`endif
            end
        endcase
        return e;
    endfunction

    // Monitor: handshakes seen at the falling edge will complete at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (in_valid && in_ready) begin
                e = model(in_op, in_rs1, in_rs2, in_tag);
                e.cyc = cyc;
                sb.push_back(e);
            end
            if (out_valid && !out_ready) begin
                if (hold_v) begin
                    check_eq("hold_rd", out_rd, hold_rd);
                    check_eq("hold_tag", {28'd0, out_tag}, {28'd0, hold_tag});
                    check_eq("hold_ill", {31'd0, out_illegal}, {31'd0, hold_ill});
                end
                hold_v = 1'b1;
                hold_rd = out_rd;
                hold_tag = out_tag;
                hold_ill = out_illegal;
            end else begin
                hold_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check_eq("rd", out_rd, e.rd);
                    check_eq("tag", {28'd0, out_tag}, {28'd0, e.tag});
                    check_eq("illegal", {31'd0, out_illegal}, {31'd0, e.ill});
                    if (lat_chk) check_eq("latency", cyc - e.cyc, 32'd2);
                end
                exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    // Random output stalls during the first part of the bulk stream.
    always @(posedge clk) begin
        if (rand_bp) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag);
        bit done = 1'b0;
        in_valid = 1'b1;
        in_op = op;
        in_rs1 = a;
        in_rs2 = b;
        in_tag = tag;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) check_eq("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clk);
            #1;
            done = (sb.size() == 0) && !busy;
        end
        if (!done) check_eq("drain_timeout", 32'd0, 32'd1);
        check_eq("count", {16'd0, op_count}, {16'd0, exp_cnt});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        sb.delete();
        exp_cnt = 16'd0;
        hold_v = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int acc;
        logic [3:0] nt;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_rs1 = 32'd0;
        in_rs2 = 32'd0;
        in_op = 2'd0;
        in_tag = 4'd0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_out_rd", out_rd, 32'd0);
        check_eq("rst_out_tag", {28'd0, out_tag}, 32'd0);
        check_eq("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_op_count", {16'd0, op_count}, 32'd0);
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // Back-to-back sign injection with latency tracking.
        lat_chk = 1'b1;
        send(2'd0, 32'h3F800000, 32'hBF800000, 4'd1);
        send(2'd1, 32'h3F800000, 32'hBF800000, 4'd2);
        send(2'd2, 32'h3F800000, 32'hBF800000, 4'd3);
        drain();
        send(2'd0, 32'hFF800900, 32'hF2802110, 4'd4);
        send(2'd1, 32'hFF800900, 32'hF2802110, 4'd5);
        send(2'd2, 32'hFF800900, 32'hF2802110, 4'd6);
        drain();
        lat_chk = 1'b0;

`ifdef FP_SIGN_EXEC_FCLASS_EN
        send(2'd3, 32'hFF800000, 32'd0, 4'd7);
        send(2'd3, 32'h80000000, 32'd0, 4'd8);
        send(2'd3, 32'h00000001, 32'd0, 4'd9);
        send(2'd3, 32'h7F800001, 32'd0, 4'd10);
        send(2'd3, 32'h7FC00000, 32'd0, 4'd11);
        send(2'd3, 32'h3F800000, 32'd0, 4'd12);
        send(2'd3, 32'h807FFFFF, 32'd0, 4'd13);
`else
        send(2'd3, 32'h7FC00000, 32'h12345678, 4'd7);
        send(2'd0, 32'h7FC00000, 32'h80000000, 4'd8);
`endif
        drain();

        // Backpressure: only two requests fit while the output is stalled.
        out_ready = 1'b0;
        acc = 0;
        nt = 4'd0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_op = 2'd1;
            in_rs1 = 32'h40000000 + {28'd0, nt};
            in_rs2 = 32'h00000000;
            in_tag = nt;
            @(negedge clk);
            if (in_ready) begin
                acc++;
                nt = nt + 4'd1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check_eq("bp_accepts", acc, 32'd2);
        check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        while (nt < 4'd4) begin
            send(2'd1, 32'h40000000 + {28'd0, nt}, 32'h00000000, nt);
            nt = nt + 4'd1;
        end
        drain();

        // Reset with two operations in flight.
        out_ready = 1'b0;
        send(2'd0, 32'h11111111, 32'h80000000, 4'd1);
        send(2'd2, 32'h22222222, 32'h80000000, 4'd2);
        check_eq("busy_inflight", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_op_count", {16'd0, op_count}, 32'd0);
        sb.delete();
        exp_cnt = 16'd0;
        hold_v = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(2'd1, 32'hC0490FDB, 32'h80000000, 4'd9);
        drain();
        check_eq("post_rst_count", {16'd0, op_count}, 32'd1);

        // Counter wrap over 65537 completions, random stalls early on.
        do_reset();
        rand_bp = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            if (i == 2000) begin
                rand_bp = 1'b0;
                #0 out_ready = 1'b1;
            end
            send(2'($urandom_range(0, 3)), $urandom, $urandom, 4'(i));
        end
        rand_bp = 1'b0;
        out_ready = 1'b1;
        drain();
        check_eq("wrap_count", {16'd0, op_count}, 32'h00000001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
